run_controller: RTL and testbench

//   Sequences one program run of the 8-bit accumulator core and shares the

---
 rtl/run_ctrl_pkg.sv | 17 +
 rtl/run_cycle_counter.sv | 27 ++
 rtl/run_controller.sv | 107 ++++++++++
 tb/tb_run_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the accumulator-core run controller.
package run_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 8;

  localparam logic [OPCODE_W-1:0] HALT_OP_DEF = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// Clear/enable cycle counter with a flag for the last allowed RUN cycle.
module run_cycle_counter #(
  parameter int unsigned           CNT_W      = 16,
  parameter logic [CNT_W-1:0]      MAX_CYCLES = 16'd4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] LAST = MAX_CYCLES - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + CNT_W'(1);
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/run_controller.sv
// Sequences one program run of the accumulator core and arbitrates the
// single-port data memory between the core and the host/loader.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter logic [OPCODE_W-1:0] HALT_OP    = HALT_OP_DEF,
  parameter int unsigned         CNT_W      = 16,
  parameter logic [CNT_W-1:0]    MAX_CYCLES = 16'd4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        inst,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);

  state_t state;
  logic   halt;
  logic   start_ok;
  logic   terminal;

  assign halt     = (inst[8:3] == HALT_OP);
  assign start_ok = start & ((state == ST_IDLE) | (state == ST_DONE));

  run_cycle_counter #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .en       (state == ST_RUN),
    .count    (cycle_count),
    .terminal (terminal)
  );

  // Outputs are registered alongside the state, so each is set on the
  // transition into the state it belongs to rather than decoded from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_CLEAR;
            busy    <= 1'b1;
            done    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state    <= ST_RUN;
          core_rst <= 1'b0;
        end
        ST_RUN: begin
          if (halt || terminal) begin
            state    <= ST_DONE;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= ~halt;
          end
        end
      endcase
    end
  end

  always_comb begin
    host_gnt  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    unique case (state)
      ST_RUN: begin
        mem_we    = core_we & ~halt;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
      ST_IDLE, ST_DONE: begin
        host_gnt = host_req;
        mem_we   = host_req & host_we;
      end
      ST_CLEAR: ;
    endcase
  end

endmodule

// File: tb/tb_run_controller.sv
// Randomized self-checking bench for run_controller (MAX_CYCLES overridden to 8).
module tb_run_controller;

  localparam int MAXC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  inst;
  logic        core_we;
  logic [7:0]  core_addr;
  logic [7:0]  core_wdata;
  logic        host_req;
  logic        host_we;
  logic [7:0]  host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  run_controller #(
    .HALT_OP    (6'b111111),
    .CNT_W      (16),
    .MAX_CYCLES (16'd8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inst        (inst),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rand_nonhalt();
    logic [8:0] v;
    v = 9'($urandom);
    if (v[8:3] == 6'b111111) v[3] = 1'b0;
    return v;
  endfunction

  task automatic rand_host();
    host_req   = 1'($urandom);
    host_we    = 1'($urandom);
    host_addr  = 8'($urandom);
    host_wdata = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; inst = 9'h000;
    core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
    #12;
    n_checks++; if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL reset_gnt got=%b exp=1", host_gnt); end
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=1", mem_we); end
    n_checks++; if (mem_addr !== 8'h10) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=10", mem_addr); end
    n_checks++; if (mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=a5", mem_wdata); end
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst got=%b exp=1", core_rst); end
    n_checks++; if (done !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags got done=%b to=%b busy=%b exp=000", done, timeout, busy); end
    n_checks++; if (cycle_count !== 16'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", cycle_count); end
    #5 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (core_rst !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold got core_rst=%b busy=%b exp=1,0", core_rst, busy); end
  endtask

  // One complete run; halt_at in 1..MAXC places a HALT on that RUN cycle,
  // anything else means the program never halts.
  task automatic test_run(input int halt_at);
    bit exp_to;
    int exp_cnt;
    bit is_halt;
    bit exp_we;
    exp_to  = !(halt_at >= 1 && halt_at <= MAXC);
    exp_cnt = exp_to ? MAXC : halt_at;

    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    inst  = rand_nonhalt();
    rand_host();
    @(negedge clk);
    n_checks++; if (core_rst !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL clear_state got core_rst=%b busy=%b exp=1,1", core_rst, busy); end
    n_checks++; if (host_gnt !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL clear_mux got gnt=%b we=%b exp=0,0", host_gnt, mem_we); end
    n_checks++; if (done !== 1'b0 || timeout !== 1'b0 || cycle_count !== 16'd0) begin n_fail++; $display("FAIL clear_cleared got done=%b to=%b cnt=%0d exp=0,0,0", done, timeout, cycle_count); end

    for (int k = 1; k <= MAXC; k++) begin
      @(posedge clk); #1;
      is_halt    = (k == halt_at);
      inst       = is_halt ? {6'b111111, 3'($urandom)} : rand_nonhalt();
      core_we    = is_halt ? 1'b1 : 1'($urandom);
      core_addr  = 8'($urandom);
      core_wdata = 8'($urandom);
      start      = ($urandom_range(0, 3) == 0);
      rand_host();
      host_req   = 1'b1;
      exp_we     = core_we && !is_halt;
      @(negedge clk);
      n_checks++; if (core_rst !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL run_state k=%0d got core_rst=%b busy=%b done=%b exp=0,1,0", k, core_rst, busy, done); end
      n_checks++; if (cycle_count !== 16'(k - 1)) begin n_fail++; $display("FAIL run_count k=%0d got=%0d exp=%0d", k, cycle_count, k - 1); end
      n_checks++; if (host_gnt !== 1'b0 || mem_we !== exp_we || mem_addr !== core_addr || mem_wdata !== core_wdata)
        begin n_fail++; $display("FAIL run_mux k=%0d got gnt=%b we=%b a=%h d=%h exp gnt=0 we=%b a=%h d=%h", k, host_gnt, mem_we, mem_addr, mem_wdata, exp_we, core_addr, core_wdata); end
      if (is_halt) break;
    end

    @(posedge clk); #1;
    start = 1'b0;
    inst  = rand_nonhalt();
    rand_host();
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || core_rst !== 1'b1) begin n_fail++; $display("FAIL done_state halt_at=%0d got done=%b busy=%b core_rst=%b exp=1,0,1", halt_at, done, busy, core_rst); end
    n_checks++; if (timeout !== exp_to) begin n_fail++; $display("FAIL done_timeout halt_at=%0d got=%b exp=%b", halt_at, timeout, exp_to); end
    n_checks++; if (cycle_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL done_count halt_at=%0d got=%0d exp=%0d", halt_at, cycle_count, exp_cnt); end
    n_checks++; if (host_gnt !== host_req || mem_we !== (host_req & host_we) || mem_addr !== host_addr || mem_wdata !== host_wdata)
      begin n_fail++; $display("FAIL done_mux got gnt=%b we=%b a=%h exp gnt=%b we=%b a=%h", host_gnt, mem_we, mem_addr, host_req, host_req & host_we, host_addr); end
    // DONE must hold its results for a few idle cycles
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b1 || cycle_count !== 16'(exp_cnt)) begin n_fail++; $display("FAIL done_hold got done=%b cnt=%0d exp=1,%0d", done, cycle_count, exp_cnt); end
  endtask

  task automatic test_halt();            test_run(5);    endtask
  task automatic test_timeout();         test_run(0);    endtask
  task automatic test_halt_at_limit();   test_run(MAXC); endtask
  task automatic test_halt_first_cycle(); test_run(1);   endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    inst  = rand_nonhalt();
    repeat (3) @(posedge clk);
    #1;
    host_req = 1'b1; host_we = 1'b0;
    rst = 1'b1;
    #2;
    n_checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_state got core_rst=%b busy=%b done=%b exp=1,0,0", core_rst, busy, done); end
    n_checks++; if (cycle_count !== 16'd0 || host_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_idle got cnt=%0d gnt=%b exp=0,1", cycle_count, host_gnt); end
    #2 rst = 1'b0;
    test_run(3);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 10; r++) test_run(int'($urandom_range(0, 11)));
  endtask

  initial begin
    test_reset();
    test_halt();
    test_timeout();
    test_halt_at_limit();
    test_halt_first_cycle();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
